// File: rtl/calc1_port_driver.sv
// Request stage for one calc1 port: buffers (cmd, op1, op2) operations, serialises them onto the
// request bus and returns the tagged response. Define CALC1_DRV_BACKTOBACK_EN to skip the idle bubble.
module calc1_port_driver #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_cmd,
  input  logic [31:0] in_op1,
  input  logic [31:0] in_op2,
  output logic [3:0]  req_cmd_out,
  output logic [31:0] req_data_out,
  input  logic [1:0]  out_resp,
  input  logic [31:0] out_data,
  output logic        rsp_valid,
  output logic [3:0]  rsp_cmd,
  output logic [1:0]  rsp_resp,
  output logic [31:0] rsp_data,
  output logic        timeout_err,
  output logic        busy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned TmrW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StCmd, StData, StWait} state_e;

  logic [3:0]      fifo_cmd_q [FIFO_DEPTH];
  logic [31:0]     fifo_op1_q [FIFO_DEPTH];
  logic [31:0]     fifo_op2_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  state_e          state_q, state_d;
  logic [TmrW-1:0] timer_q, timer_d;
  logic [3:0]      cur_cmd_q, cur_cmd_d;
  logic [31:0]     cur_op2_q, cur_op2_d;
  logic [3:0]      req_cmd_q, req_cmd_d;
  logic [31:0]     req_data_q, req_data_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [3:0]      rsp_cmd_q, rsp_cmd_d;
  logic [1:0]      rsp_resp_q, rsp_resp_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic            timeout_err_q, timeout_err_d;

  logic fifo_full, fifo_empty, push, pop, resp_hit, timer_expired;

  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = in_valid && !fifo_full;
  // X or Z on out_resp must never look like a response, hence case-equality.
  assign resp_hit   = (out_resp === 2'b01) || (out_resp === 2'b10) || (out_resp === 2'b11);
  assign timer_expired = (timer_q == TmrW'(TIMEOUT - 1));

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    cur_cmd_d     = cur_cmd_q;
    cur_op2_d     = cur_op2_q;
    req_cmd_d     = 4'd0;
    req_data_d    = 32'd0;
    rsp_valid_d   = 1'b0;
    rsp_cmd_d     = rsp_cmd_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_data_d    = rsp_data_q;
    timeout_err_d = 1'b0;
    pop           = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          cur_cmd_d  = fifo_cmd_q[rd_ptr_q];
          cur_op2_d  = fifo_op2_q[rd_ptr_q];
          req_cmd_d  = fifo_cmd_q[rd_ptr_q];
          req_data_d = fifo_op1_q[rd_ptr_q];
          state_d    = StCmd;
        end
      end
      StCmd: begin
        req_data_d = cur_op2_q;
        state_d    = StData;
      end
      StData: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        if (resp_hit || timer_expired) begin
          rsp_valid_d   = 1'b1;
          rsp_cmd_d     = cur_cmd_q;
          rsp_resp_d    = resp_hit ? out_resp : 2'b00;
          rsp_data_d    = resp_hit ? out_data : 32'd0;
          timeout_err_d = !resp_hit;
          state_d       = StIdle;
`ifdef CALC1_DRV_BACKTOBACK_EN
          if (!fifo_empty) begin
            pop        = 1'b1;
            cur_cmd_d  = fifo_cmd_q[rd_ptr_q];
            cur_op2_d  = fifo_op2_q[rd_ptr_q];
            req_cmd_d  = fifo_cmd_q[rd_ptr_q];
            req_data_d = fifo_op1_q[rd_ptr_q];
            state_d    = StCmd;
          end
`endif
        end else begin
          timer_d = timer_q + TmrW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge c_clk) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= StIdle;
      timer_q       <= '0;
      cur_cmd_q     <= 4'd0;
      cur_op2_q     <= 32'd0;
      req_cmd_q     <= 4'd0;
      req_data_q    <= 32'd0;
      rsp_valid_q   <= 1'b0;
      rsp_cmd_q     <= 4'd0;
      rsp_resp_q    <= 2'b00;
      rsp_data_q    <= 32'd0;
      timeout_err_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      timer_q       <= timer_d;
      cur_cmd_q     <= cur_cmd_d;
      cur_op2_q     <= cur_op2_d;
      req_cmd_q     <= req_cmd_d;
      req_data_q    <= req_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_cmd_q     <= rsp_cmd_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_data_q    <= rsp_data_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge c_clk) begin
    if (push) begin
      fifo_cmd_q[wr_ptr_q] <= in_cmd;
      fifo_op1_q[wr_ptr_q] <= in_op1;
      fifo_op2_q[wr_ptr_q] <= in_op2;
    end
  end

  assign in_ready     = !fifo_full;
  assign req_cmd_out  = req_cmd_q;
  assign req_data_out = req_data_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_cmd      = rsp_cmd_q;
  assign rsp_resp     = rsp_resp_q;
  assign rsp_data     = rsp_data_q;
  assign timeout_err  = timeout_err_q;
  assign busy         = (state_q != StIdle) || !fifo_empty;

endmodule
